pipe_sequencer: RTL and testbench

//  Sequences the 5-stage pipeline (IF/ID/EXE/MEM/WB): global advance enable, RAW-hazard stall

---
 rtl/pipe_sequencer.sv | 150 +++++++++++++++
 tb/tb_pipe_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sequencer.sv
// Five-stage pipeline sequencer: advance enable, RAW stall bubbles, redirect flushes,
// PC-source select, EPC capture, double-fault freeze and single-step debug.
module pipe_sequencer #(
  parameter int                ADDR_W  = 8,
  parameter logic [ADDR_W-1:0] EXC_VEC = 8'h80,
  parameter int                CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              step_mode_i,
  input  logic              step_req_i,
  input  logic [4:0]        id_rs_i,
  input  logic [4:0]        id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic              exe_wr_i,
  input  logic              mem_wr_i,
  input  logic [4:0]        exe_dst_i,
  input  logic [4:0]        mem_dst_i,
  input  logic              id_jump_i,
  input  logic              mem_branch_i,
  input  logic              exe_exc_i,
  input  logic [ADDR_W-1:0] exe_pc_i,
  input  logic              epc_clr_i,
  output logic              pipe_en_o,
  output logic              pc_we_o,
  output logic              if_id_we_o,
  output logic              if_id_flush_o,
  output logic              id_exe_flush_o,
  output logic              exe_mem_flush_o,
  output logic [1:0]        pc_sel_o,
  output logic [ADDR_W-1:0] epc_o,
  output logic              epc_valid_o,
  output logic              fault_o,
  output logic              step_ack_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  // state | meaning
  // RUN   | free-running, every cycle advances
  // HOLD  | single-step mode, pipeline frozen waiting for step_req
  // STEP  | single advance cycle of a debug step
  // FAULT | double fault, frozen until epc_clr
  typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_STEP, ST_FAULT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] epc_q;
  logic              epc_valid_q;
  logic [CNT_W-1:0]  stall_q, flush_q;

  logic adv, raw_exe, raw_mem, raw;
  logic exc_act, capture, stall_inc, flush_inc;
  logic pe, pw, iw, f1, f2, f3;
  logic [1:0] sel;

  assign raw_exe = exe_wr_i && (exe_dst_i != 5'd0) &&
                   ((exe_dst_i == id_rs_i) || (id_uses_rt_i && (exe_dst_i == id_rt_i)));
  assign raw_mem = mem_wr_i && (mem_dst_i != 5'd0) &&
                   ((mem_dst_i == id_rs_i) || (id_uses_rt_i && (mem_dst_i == id_rt_i)));
  assign raw     = raw_exe || raw_mem;
  assign adv     = (state_q == ST_RUN) || (state_q == ST_STEP);

  always_comb begin
    pe        = 1'b0;
    pw        = 1'b0;
    iw        = 1'b0;
    f1        = 1'b0;
    f2        = 1'b0;
    f3        = 1'b0;
    sel       = 2'b00;
    exc_act   = 1'b0;
    capture   = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    state_d   = state_q;
    case (state_q)
      ST_RUN, ST_STEP: begin
        pe      = 1'b1;
        state_d = step_mode_i ? ST_HOLD : ST_RUN;
        if (exe_exc_i) begin
          exc_act   = 1'b1;
          sel       = 2'b11;
          {f1, f2, f3} = 3'b111;
          iw        = 1'b1;
          flush_inc = 1'b1;
          // An exception while EPC is still unserviced is a double fault.
          if (epc_valid_q) state_d = ST_FAULT;
          else begin
            pw      = 1'b1;
            capture = 1'b1;
          end
        end else if (mem_branch_i) begin
          sel       = 2'b01;
          {f1, f2, f3} = 3'b111;
          {pw, iw}  = 2'b11;
          flush_inc = 1'b1;
        end else if (id_jump_i) begin
          sel       = 2'b10;
          f1        = 1'b1;
          {pw, iw}  = 2'b11;
          flush_inc = 1'b1;
        end else if (raw) begin
          f2        = 1'b1;
          stall_inc = 1'b1;
        end else begin
          {pw, iw}  = 2'b11;
        end
      end
      ST_HOLD: begin
        if (!step_mode_i)    state_d = ST_RUN;
        else if (step_req_i) state_d = ST_STEP;
      end
      default: begin
        if (epc_clr_i) state_d = step_mode_i ? ST_HOLD : ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_RUN;
      epc_q       <= '0;
      epc_valid_q <= 1'b0;
      stall_q     <= '0;
      flush_q     <= '0;
    end else begin
      state_q <= state_d;
      if (capture) epc_q <= exe_pc_i - ADDR_W'(4);
      if (exc_act)        epc_valid_q <= 1'b1;
      else if (epc_clr_i) epc_valid_q <= 1'b0;
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign pipe_en_o       = !reset_i && pe;
  assign pc_we_o         = !reset_i && pw;
  assign if_id_we_o      = !reset_i && iw;
  assign if_id_flush_o   = !reset_i && f1;
  assign id_exe_flush_o  = !reset_i && f2;
  assign exe_mem_flush_o = !reset_i && f3;
  assign pc_sel_o        = reset_i ? 2'b00 : sel;
  assign epc_o           = reset_i ? '0 : epc_q;
  assign epc_valid_o     = !reset_i && epc_valid_q;
  assign fault_o         = !reset_i && (state_q == ST_FAULT);
  assign step_ack_o      = !reset_i && (state_q == ST_STEP);
  assign stall_cnt_o     = reset_i ? '0 : stall_q;
  assign flush_cnt_o     = reset_i ? '0 : flush_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Scoreboard bench for pipe_sequencer: a cycle-level reference model pushes expected outputs,
// a monitor pops and compares them; a CNT_W=4 instance shares the stimulus to exercise saturation.
module tb_pipe_sequencer;

  typedef struct packed {
    logic rst, sm, sr, urt, ewr, mwr, jmp, br, exc, clr;
    logic [4:0] rs, rt, ed, md;
    logic [7:0] pc;
  } stim_t;

  typedef struct packed {
    logic pe, pw, iw, f1, f2, f3;
    logic [1:0] sel;
    logic [7:0] epc;
    logic ev, flt, ack;
    logic [15:0] sc, fc;
    logic [3:0] sc4, fc4;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  stim_t s;
  logic pe, pw, iw, f1, f2, f3, ev, flt, ack;
  logic pe4, pw4, iw4, f14, f24, f34, ev4, flt4, ack4;
  logic [1:0] sel, sel4;
  logic [7:0] epc, epc4;
  logic [15:0] sc, fc;
  logic [3:0] sc4, fc4;

  pipe_sequencer dut (
    .clk_i(clk), .reset_i(s.rst), .step_mode_i(s.sm), .step_req_i(s.sr),
    .id_rs_i(s.rs), .id_rt_i(s.rt), .id_uses_rt_i(s.urt), .exe_wr_i(s.ewr), .mem_wr_i(s.mwr),
    .exe_dst_i(s.ed), .mem_dst_i(s.md), .id_jump_i(s.jmp), .mem_branch_i(s.br),
    .exe_exc_i(s.exc), .exe_pc_i(s.pc), .epc_clr_i(s.clr),
    .pipe_en_o(pe), .pc_we_o(pw), .if_id_we_o(iw), .if_id_flush_o(f1), .id_exe_flush_o(f2),
    .exe_mem_flush_o(f3), .pc_sel_o(sel), .epc_o(epc), .epc_valid_o(ev), .fault_o(flt),
    .step_ack_o(ack), .stall_cnt_o(sc), .flush_cnt_o(fc));

  pipe_sequencer #(.CNT_W(4)) dut4 (
    .clk_i(clk), .reset_i(s.rst), .step_mode_i(s.sm), .step_req_i(s.sr),
    .id_rs_i(s.rs), .id_rt_i(s.rt), .id_uses_rt_i(s.urt), .exe_wr_i(s.ewr), .mem_wr_i(s.mwr),
    .exe_dst_i(s.ed), .mem_dst_i(s.md), .id_jump_i(s.jmp), .mem_branch_i(s.br),
    .exe_exc_i(s.exc), .exe_pc_i(s.pc), .epc_clr_i(s.clr),
    .pipe_en_o(pe4), .pc_we_o(pw4), .if_id_we_o(iw4), .if_id_flush_o(f14), .id_exe_flush_o(f24),
    .exe_mem_flush_o(f34), .pc_sel_o(sel4), .epc_o(epc4), .epc_valid_o(ev4), .fault_o(flt4),
    .step_ack_o(ack4), .stall_cnt_o(sc4), .flush_cnt_o(fc4));

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: operating mode, exception bookkeeping and event tallies.
  localparam int M_RUN = 0, M_HOLD = 1, M_STEP = 2, M_FAULT = 3;
  int         mode = M_RUN;
  logic [7:0] m_epc = 8'h00;
  bit         m_ev = 1'b0;
  int         stalls = 0, redirects = 0;

  function automatic bit hazard(input stim_t t);
    bit hit = 1'b0;
    if (t.ewr && t.ed != 0 && (t.ed == t.rs || (t.urt && t.ed == t.rt))) hit = 1'b1;
    if (t.mwr && t.md != 0 && (t.md == t.rs || (t.urt && t.md == t.rt))) hit = 1'b1;
    return hit;
  endfunction

  task automatic model(input stim_t t);
    exp_t e = '0;
    int   nxt;
    bit   advancing;
    if (t.rst) begin
      exp_q.push_back(e);
      mode = M_RUN; m_epc = 8'h00; m_ev = 1'b0; stalls = 0; redirects = 0;
      return;
    end
    e.epc = m_epc;  e.ev = m_ev;  e.flt = (mode == M_FAULT);  e.ack = (mode == M_STEP);
    e.sc  = (stalls > 65535) ? 16'hFFFF : 16'(stalls);
    e.fc  = (redirects > 65535) ? 16'hFFFF : 16'(redirects);
    e.sc4 = (stalls > 15) ? 4'hF : 4'(stalls);
    e.fc4 = (redirects > 15) ? 4'hF : 4'(redirects);
    advancing = (mode == M_RUN || mode == M_STEP);
    nxt = mode;
    if (advancing) begin
      e.pe = 1'b1;
      nxt = t.sm ? M_HOLD : M_RUN;
      if (t.exc) begin
        e.sel = 2'b11; e.f1 = 1; e.f2 = 1; e.f3 = 1; e.iw = 1; redirects++;
        if (m_ev) nxt = M_FAULT;
        else begin e.pw = 1; m_epc = t.pc - 8'd4; end
        m_ev = 1'b1;
      end else begin
        if (t.br) begin
          e.sel = 2'b01; e.f1 = 1; e.f2 = 1; e.f3 = 1; e.pw = 1; e.iw = 1; redirects++;
        end else if (t.jmp) begin
          e.sel = 2'b10; e.f1 = 1; e.pw = 1; e.iw = 1; redirects++;
        end else if (hazard(t)) begin
          e.f2 = 1; stalls++;
        end else begin
          e.pw = 1; e.iw = 1;
        end
        if (t.clr) m_ev = 1'b0;
      end
    end else begin
      if (t.clr) m_ev = 1'b0;
      if (mode == M_HOLD) nxt = !t.sm ? M_RUN : (t.sr ? M_STEP : M_HOLD);
      else if (t.clr) nxt = t.sm ? M_HOLD : M_RUN;
    end
    mode = nxt;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input stim_t t);
    @(negedge clk);
    s = t;
    model(t);
  endtask

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pipe_en", pe, e.pe);          chk("pc_we", pw, e.pw);
        chk("if_id_we", iw, e.iw);         chk("if_id_flush", f1, e.f1);
        chk("id_exe_flush", f2, e.f2);     chk("exe_mem_flush", f3, e.f3);
        chk("pc_sel", sel, e.sel);         chk("epc", epc, e.epc);
        chk("epc_valid", ev, e.ev);        chk("fault", flt, e.flt);
        chk("step_ack", ack, e.ack);       chk("stall_cnt", sc, e.sc);
        chk("flush_cnt", fc, e.fc);        chk("stall_cnt4", sc4, e.sc4);
        chk("flush_cnt4", fc4, e.fc4);     chk("pipe_en4", pe4, e.pe);
        chk("pc_sel4", sel4, e.sel);       chk("fault4", flt4, e.flt);
      end
    end
  end

  initial begin : driver
    stim_t t;
    s = '0;
    s.rst = 1'b1;
    t = '0; t.rst = 1'b1;
    repeat (3) cyc(t);
    t = '0;
    cyc(t);
    // RAW on EXE destination, then the zero register never stalls
    t = '0; t.ewr = 1; t.ed = 5; t.rs = 5;
    repeat (2) cyc(t);
    t.ed = 0; cyc(t);
    // branch beats jump
    t = '0; t.br = 1; t.jmp = 1; cyc(t);
    // exception capture, then a double fault held until epc_clr
    t = '0; t.exc = 1; t.pc = 8'h14; cyc(t);
    t = '0; repeat (2) cyc(t);
    t.exc = 1; t.pc = 8'h40; cyc(t);
    t = '0; repeat (3) cyc(t);
    t.clr = 1; cyc(t);
    t = '0; repeat (2) cyc(t);
    // single-step: two requests five cycles apart
    t = '0; t.sm = 1; repeat (2) cyc(t);
    t.sr = 1; cyc(t); t.sr = 0; repeat (4) cyc(t);
    t.sr = 1; cyc(t); t.sr = 0; repeat (4) cyc(t);
    t.sm = 0; cyc(t);
    // long MEM-path RAW on rt pushes the 4-bit counter into saturation
    t = '0; t.mwr = 1; t.md = 7; t.rt = 7; t.urt = 1;
    repeat (20) cyc(t);
    for (int i = 0; i < 3000; i++) begin
      t.rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) t.sm = ~t.sm;
      t.sr  = ($urandom_range(0, 3) == 0);
      t.rs  = 5'($urandom_range(0, 3));
      t.rt  = 5'($urandom_range(0, 3));
      t.ed  = 5'($urandom_range(0, 3));
      t.md  = 5'($urandom_range(0, 3));
      t.urt = 1'($urandom);
      t.ewr = 1'($urandom);
      t.mwr = 1'($urandom);
      t.jmp = ($urandom_range(0, 7) == 0);
      t.br  = ($urandom_range(0, 9) == 0);
      t.exc = ($urandom_range(0, 24) == 0);
      t.clr = ($urandom_range(0, 9) == 0);
      t.pc  = 8'($urandom);
      cyc(t);
    end
    @(negedge clk);
    #4;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
